// File: rtl/reg_wb_arbiter_pkg.sv
// Shared defaults and FSM encoding for the register write-back arbiter.
package reg_wb_arbiter_pkg;

    localparam int W_DEF            = 8;
    localparam int D_DEF            = 4;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CARRY = 1'b1
    } state_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive ALU wins taken while the load port was waiting.
module wb_starve_ctr #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (inc && (count_q != LIM_C)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == LIM_C);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates ALU and load write-backs onto one register-file write port,
// with a follow-up carry write and in-flight hazard flags for two read ports.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int D            = D_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluValid,
    output logic         AluReady,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    input  logic         AluCarryEn,
    input  logic [D-1:0] AluCarryAddr,
    input  logic         AluCarry,
    input  logic         MemValid,
    output logic         MemReady,
    input  logic [D-1:0] MemAddr,
    input  logic [W-1:0] MemData,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrAccum,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] WriteData,
    output logic         PendA,
    output logic         PendAccum
);

    state_e         state_q, state_d;
    logic [D-1:0]   carry_addr_q, carry_addr_d;
    logic           carry_bit_q, carry_bit_d;
    logic           write_en_q, write_en_d;
    logic [D-1:0]   waddr_q, waddr_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic           alu_sel_s, mem_sel_s;
    logic           alu_grant_s, mem_grant_s;
    logic           at_limit_s;

    wb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (Clk),
        .rst_n    (Reset),
        .inc      (alu_grant_s & MemValid),
        .clr      (mem_grant_s | ~MemValid),
        .at_limit (at_limit_s)
    );

    // Requester selection; nobody is offered the port while a carry write is owed.
    always_comb begin
        alu_sel_s = 1'b0;
        mem_sel_s = 1'b0;
        if (state_q == IDLE) begin
            if (AluValid && MemValid) begin
                if (at_limit_s) begin
                    mem_sel_s = 1'b1;
                end else begin
                    alu_sel_s = 1'b1;
                end
            end else if (AluValid) begin
                alu_sel_s = 1'b1;
            end else if (MemValid) begin
                mem_sel_s = 1'b1;
            end else begin
                alu_sel_s = 1'b0;
                mem_sel_s = 1'b0;
            end
        end else begin
            alu_sel_s = 1'b0;
            mem_sel_s = 1'b0;
        end
    end

    assign AluReady    = alu_sel_s & Reset;
    assign MemReady    = mem_sel_s & Reset;
    assign alu_grant_s = AluValid & AluReady;
    assign mem_grant_s = MemValid & MemReady;

    // Next state and next write-port contents; address/data hold when idle.
    always_comb begin
        state_d      = state_q;
        carry_addr_d = carry_addr_q;
        carry_bit_d  = carry_bit_q;
        write_en_d   = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        case (state_q)
            CARRY: begin
                write_en_d = 1'b1;
                waddr_d    = carry_addr_q;
                wdata_d    = {{(W-1){1'b0}}, carry_bit_q};
                state_d    = IDLE;
            end
            IDLE: begin
                if (alu_grant_s) begin
                    write_en_d = 1'b1;
                    waddr_d    = AluAddr;
                    wdata_d    = AluData;
                    if (AluCarryEn) begin
                        state_d      = CARRY;
                        carry_addr_d = AluCarryAddr;
                        carry_bit_d  = AluCarry;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (mem_grant_s) begin
                    write_en_d = 1'b1;
                    waddr_d    = MemAddr;
                    wdata_d    = MemData;
                end else begin
                    write_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, carry latch and registered write port.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            carry_addr_q <= {D{1'b0}};
            carry_bit_q  <= 1'b0;
            write_en_q   <= 1'b0;
            waddr_q      <= {D{1'b0}};
            wdata_q      <= {W{1'b0}};
        end else begin
            state_q      <= state_d;
            carry_addr_q <= carry_addr_d;
            carry_bit_q  <= carry_bit_d;
            write_en_q   <= write_en_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign WriteEn   = write_en_q;
    assign Waddr     = waddr_q;
    assign WriteData = wdata_q;

    // A read is hazardous if the current write or the owed carry write targets it.
    assign PendA     = Reset & ((write_en_q && (waddr_q == RaddrA)) ||
                                ((state_q == CARRY) && (carry_addr_q == RaddrA)));
    assign PendAccum = Reset & ((write_en_q && (waddr_q == RaddrAccum)) ||
                                ((state_q == CARRY) && (carry_addr_q == RaddrAccum)));

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning register data width.
REQ-002 The block SHALL have parameter D, default 4, meaning register address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 3, meaning the number of consecutive ALU grants allowed while MEM waits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- Clk  in  1  sole clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- AluValid  in  1  ALU write request.
- AluReady  out  1  ALU request accepted this cycle.
- AluAddr  in  D  ALU result destination.
- AluData  in  W  ALU result.
- AluCarryEn  in  1  request also carries a carry-out write.
- AluCarryAddr  in  D  carry destination.
- AluCarry  in  1  carry-out bit.
- MemValid  in  1  load write request.
- MemReady  out  1  load request accepted this cycle.
- MemAddr  in  D  load destination.
- MemData  in  W  load data.
- RaddrA  in  D  read address A, for hazard check.
- RaddrAccum  in  D  accumulator read address, for hazard check.
- WriteEn  out  1  register-file write enable.
- Waddr  out  D  register-file write address.
- WriteData  out  W  register-file write data.
- PendA  out  1  a write to RaddrA is in flight.
- PendAccum  out  1  a write to RaddrAccum is in flight.

Function
REQ-005 A transfer SHALL occur only when Valid and Ready are both high in the same cycle.
REQ-006 WriteEn, Waddr and WriteData SHALL be registered, so a request accepted in cycle t is written in cycle t+1.
REQ-007 The FSM SHALL have exactly two states: IDLE and CARRY.
REQ-008 In IDLE, when both requesters are valid, ALU SHALL win unless the starvation count equals STARVE_LIMIT, in which case MEM SHALL win.
REQ-009 At most one of AluReady and MemReady SHALL be high in any cycle.
REQ-010 Ready SHALL be high in IDLE for the selected valid requester, or for any sole valid requester.
REQ-011 When an ALU request is accepted with AluCarryEn=1, the FSM SHALL move to CARRY and latch AluCarryAddr and AluCarry.
REQ-012 In CARRY, the block SHALL drive AluReady=0 and MemReady=0.
REQ-013 In CARRY, the block SHALL issue the carry write (data = AluCarry zero-extended to W) in the following cycle, then return to IDLE.
REQ-014 A carry-enabled ALU op SHALL produce a result write at t+1 and a carry write at t+2, with the earliest next acceptance at t+2.
REQ-015 If AluAddr equals AluCarryAddr, the block SHALL perform both writes in order, so the carry value is final.
REQ-016 The starvation counter SHALL increment on each ALU grant made while MemValid=1, and SHALL saturate at STARVE_LIMIT.
REQ-017 The starvation counter SHALL clear on a MEM grant or on any cycle with MemValid=0.
REQ-018 When no transfer occurs and the FSM is not in CARRY, the next cycle SHALL have WriteEn=0; Waddr and WriteData SHALL hold their previous values.
REQ-019 PendA SHALL be high when WriteEn=1 and Waddr==RaddrA, or when the FSM is in CARRY and the latched carry address equals RaddrA.
REQ-020 PendAccum SHALL follow the rule of REQ-019 using RaddrAccum.
REQ-021 PendA and PendAccum SHALL be combinational.
REQ-022 Valid signals SHALL be allowed to drop without a handshake; the block SHALL hold no request it has not accepted.

Reset
REQ-023 Asserting Reset SHALL immediately force: FSM=IDLE, WriteEn=0, Waddr=0, WriteData=0, starvation count=0, latched carry address/bit=0.
REQ-024 Asserting Reset in CARRY SHALL discard the pending carry write.
REQ-025 While Reset is low, AluReady, MemReady, PendA and PendAccum SHALL be 0.
REQ-026 The first acceptance SHALL be possible in the first rising edge after Reset deasserts.

Structure
REQ-027 A shared package SHALL hold the W/D defaults, STARVE_LIMIT, and the state encoding (IDLE=0, CARRY=1).
REQ-028 The starvation counter SHALL be a sub-module named wb_starve_ctr, with inputs inc/clr and output at_limit.
REQ-029 The rest of the block SHALL be a single module.

Verification
REQ-030 ALU only: AluAddr=3, AluData=0x5A, CarryEn=0 -> next cycle WriteEn=1, Waddr=3, WriteData=0x5A; the cycle after, WriteEn=0.
REQ-031 Carry op: AluAddr=0, AluData=0xFF, CarryEn=1, CarryAddr=7, Carry=1 -> t+1 writes r0=0xFF; t+2 writes r7=0x01; AluReady=0 at t+1.
REQ-032 Starvation: both valid for 5 cycles, no carry -> grants are ALU, ALU, ALU, MEM, ALU.
REQ-033 Hazard: in CARRY with CarryAddr=7 and RaddrA=7 -> PendA=1; with RaddrA=6 -> PendA=0.
REQ-034 Reset mid-CARRY: assert Reset in cycle t+1 of a carry op -> no carry write occurs, WriteEn=0, and the FSM is IDLE after release.
